spi_rx: RTL

SPI receive monitor for the logic analyzer's protocol-trigger path. It passively observes SS_n/SCLK/MOSI from the probed bus or from the on-chip SPI master transmitter, and deserializes each 8- or 16-bit frame. It flags complete frames and malformed frames, and raises a trigger pulse when a received word matches a masked pattern. All pin inputs are asynchronous to clk and are synchronized internally.

---
 rtl/spi_rx.sv | 107 ++++++++++
 1 files changed

// File: rtl/spi_rx.sv
// spi_rx: passive SPI receive monitor for the protocol-trigger path.
// Pins SS_n/SCLK/MOSI are asynchronous to clk and are synchronized here.
// Each 8- or 16-bit frame is deserialized MSB first. A good frame pulses rdy
// (and SPItrig on a masked match). A frame with a wrong bit count pulses err.
module spi_rx (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   input  logic        edg,
   input  logic        width8,
   input  logic [15:0] match,
   input  logic [15:0] mask,
   output logic [15:0] rx_data,
   output logic        rdy,
   output logic        err,
   output logic        SPItrig
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RX   = 1'b1
   } state_t;

   state_t      state;
   logic        ss_ff1, ss_ff2;
   logic        sclk_ff1, sclk_ff2, sclk_ff3;
   logic        mosi_ff1, mosi_ff2;
   logic [15:0] shft;
   logic [4:0]  cnt;
   logic        strobe;
   logic        len_ok;
   logic [15:0] word;

   // Two-flop synchronizers; SCLK gets a third flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_ff1   <= 1'b1;
         ss_ff2   <= 1'b1;
         sclk_ff1 <= 1'b0;
         sclk_ff2 <= 1'b0;
         sclk_ff3 <= 1'b0;
         mosi_ff1 <= 1'b0;
         mosi_ff2 <= 1'b0;
      end else begin
         ss_ff1   <= SS_n;
         ss_ff2   <= ss_ff1;
         sclk_ff1 <= SCLK;
         sclk_ff2 <= sclk_ff1;
         sclk_ff3 <= sclk_ff2;
         mosi_ff1 <= MOSI;
         mosi_ff2 <= mosi_ff1;
      end
   end

   // Sample strobe on the selected synchronized SCLK edge, plus frame checks.
   always_comb begin
      strobe = edg ? (sclk_ff2 & ~sclk_ff3) : (~sclk_ff2 & sclk_ff3);
      len_ok = width8 ? (cnt == 5'd8) : (cnt == 5'd16);
      word   = width8 ? {8'h00, shft[7:0]} : shft;
   end

   // Frame state machine with registered result pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         shft    <= '0;
         cnt     <= '0;
         rx_data <= '0;
         rdy     <= 1'b0;
         err     <= 1'b0;
         SPItrig <= 1'b0;
      end else begin
         rdy     <= 1'b0;
         err     <= 1'b0;
         SPItrig <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (!ss_ff2)
                  state <= RX;
            end
            RX: begin
               // Deselect takes priority over a coincident strobe so the
               // frame length is judged on edges seen while selected.
               if (ss_ff2) begin
                  state <= IDLE;
                  if (len_ok) begin
                     rx_data <= word;
                     rdy     <= 1'b1;
                     SPItrig <= (((word ^ match) & ~mask) == 16'h0000);
                  end else begin
                     err <= 1'b1;
                  end
               end else if (strobe) begin
                  shft <= {shft[14:0], mosi_ff2};
                  if (cnt != 5'd31)
                     cnt <= cnt + 5'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
